audio_gain: RTL and testbench

Stereo digital volume stage in the 12.288 MHz audio domain. It sits between the i2s block's receive outputs (o_audio_l/o_audio_r/o_audio_valid) and its transmit inputs (i_audio_l/i_audio_r). Each received frame is scaled by a slewed gain with a click-free soft mute, and results are saturated to 16 bits. One shared signed multiplier is time-multiplexed between channels by a small FSM.

---
 rtl/audio_pkg.sv | 53 +++++
 rtl/audio_gain_ramp.sv | 49 ++++
 rtl/audio_gain.sv | 171 +++++++++++++++++
 tb/tb_audio_gain.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared types and helpers for the audio_gain volume stage.
//   sample_t   : signed 16-bit PCM sample
//   GAIN_UNITY : Q1.7 gain code for 1.0
//   SHIFT      : fractional bits of the gain (product >>> SHIFT restores scale)
//   state_t    : multiplier-sharing FSM states
//   sat16()    : scale a 25-bit product back to a sample with clip flag
// -----------------------------------------------------------------------------
package audio_pkg;

    typedef logic signed [15:0] sample_t;

    localparam int GAIN_UNITY = 128;
    localparam int SHIFT      = 7;

    // 16-bit signed sample times 9-bit non-negative gain {1'b0, gain}.
    localparam int PROD_W = 25;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_L = 2'd1,
        MUL_R = 2'd2,
        SAT   = 2'd3
    } state_t;

    typedef struct packed {
        logic    clip;
        sample_t sample;
    } sat_t;

    localparam logic signed [PROD_W-1:0] SAT_MAX = 25'sd32767;
    localparam logic signed [PROD_W-1:0] SAT_MIN = -25'sd32768;

    // Arithmetic shift floors toward minus infinity, so -1 * 0.5 stays -1.
    function automatic sat_t sat16(input logic signed [PROD_W-1:0] prod);
        logic signed [PROD_W-1:0] shifted;
        sat_t                     res;
        shifted = prod >>> SHIFT;
        if (shifted > SAT_MAX) begin
            res.sample = 16'sh7FFF;
            res.clip   = 1'b1;
        end else if (shifted < SAT_MIN) begin
            res.sample = 16'sh8000;
            res.clip   = 1'b1;
        end else begin
            res.sample = shifted[15:0];
            res.clip   = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/audio_gain_ramp.sv
// -----------------------------------------------------------------------------
// audio_gain_ramp
// Gain slew register. On each i_step_en pulse the current gain moves toward
// i_target by RAMP_STEP, landing exactly on the target rather than overshooting.
// Resets to 0 so every reset yields a fade-in.
//   i_clk_12_288 : audio clock
//   i_reset_n    : asynchronous active-low reset
//   i_target     : gain to approach (already forced to 0 when muted)
//   i_step_en    : one step per accepted frame
//   o_gain_cur   : current gain, Q1.7
// -----------------------------------------------------------------------------
module audio_gain_ramp #(
    parameter int GAIN_W    = 8,
    parameter int RAMP_STEP = 1
) (
    input  logic              i_clk_12_288,
    input  logic              i_reset_n,
    input  logic [GAIN_W-1:0] i_target,
    input  logic              i_step_en,
    output logic [GAIN_W-1:0] o_gain_cur
);

    localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);

    logic [GAIN_W-1:0] r_gain;
    logic [GAIN_W-1:0] w_gain_next;

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_gain_next = r_gain;
        if (r_gain < i_target) begin
            w_gain_next = (i_target - r_gain > STEP) ? r_gain + STEP : i_target;
        end else if (r_gain > i_target) begin
            w_gain_next = (r_gain - i_target > STEP) ? r_gain - STEP : i_target;
        end
    end

    always_ff @(posedge i_clk_12_288 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_gain <= '0;
        end else if (i_step_en) begin
            r_gain <= w_gain_next;
        end
    end

    assign o_gain_cur = r_gain;

endmodule

// File: rtl/audio_gain.sv
// -----------------------------------------------------------------------------
// audio_gain
// Stereo digital volume stage between i2s rx and i2s tx. Each new frame is
// scaled by a slewed Q1.7 gain (soft mute ramps to 0), saturated to 16 bits.
// One signed multiplier is shared between channels: IDLE -> MUL_L -> MUL_R ->
// SAT, outputs appear four cycles after the accepted strobe edge.
//   i_clk_12_288  : audio clock, only clock
//   i_reset_n     : asynchronous active-low reset
//   i_audio_l/r   : signed samples from i2s rx
//   i_audio_valid : new-frame strobe (level; its rising edge starts a frame)
//   i_gain        : target gain, Q1.7, 128 = unity
//   i_mute        : forces target gain to 0
//   o_audio_l/r   : scaled samples, held between updates
//   o_audio_valid : one-cycle pulse when outputs update
//   o_clip        : pulse with o_audio_valid when either channel saturated
//   o_gain_cur    : gain applied to the most recent frame
// GAIN_W must stay 8: the shared product width in audio_pkg is sized for it.
// -----------------------------------------------------------------------------
module audio_gain
    import audio_pkg::*;
#(
    parameter int GAIN_W    = 8,
    parameter int RAMP_STEP = 1
) (
    input  logic               i_clk_12_288,
    input  logic               i_reset_n,
    input  logic signed [15:0] i_audio_l,
    input  logic signed [15:0] i_audio_r,
    input  logic               i_audio_valid,
    input  logic [GAIN_W-1:0]  i_gain,
    input  logic               i_mute,
    output logic signed [15:0] o_audio_l,
    output logic signed [15:0] o_audio_r,
    output logic               o_audio_valid,
    output logic               o_clip,
    output logic [GAIN_W-1:0]  o_gain_cur
);

    state_t r_state;
    state_t w_state_next;

    logic              r_valid_d;
    sample_t           r_sample_l;
    sample_t           r_sample_r;
    logic signed [PROD_W-1:0] r_prod_l;
    logic signed [PROD_W-1:0] r_prod_r;
    sample_t           r_audio_l;
    sample_t           r_audio_r;
    logic              r_audio_valid;
    logic              r_clip;

    logic              w_edge;
    logic              w_capture;
    logic              w_load_l;
    logic              w_load_r;
    logic              w_load_out;
    logic              w_sel_r;
    logic [GAIN_W-1:0] w_target;
    logic [GAIN_W-1:0] w_gain_cur;
    sample_t           w_mul_sample;
    logic signed [PROD_W-1:0] w_mul_a;
    logic signed [PROD_W-1:0] w_mul_b;
    logic signed [PROD_W-1:0] w_prod;
    sat_t              w_sat_l;
    sat_t              w_sat_r;

    // Rising edge of the strobe, so a level held for several cycles counts once.
    assign w_edge   = i_audio_valid & ~r_valid_d;
    assign w_target = i_mute ? '0 : i_gain;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk_12_288 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_edge) w_state_next = MUL_L;
            MUL_L:   w_state_next = MUL_R;
            MUL_R:   w_state_next = SAT;
            SAT:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_capture  = 1'b0;
        w_load_l   = 1'b0;
        w_load_r   = 1'b0;
        w_load_out = 1'b0;
        w_sel_r    = 1'b0;
        case (r_state)
            IDLE:  w_capture  = w_edge;
            MUL_L: w_load_l   = 1'b1;
            MUL_R: begin
                w_load_r = 1'b1;
                w_sel_r  = 1'b1;
            end
            SAT:   w_load_out = 1'b1;
            default: ;
        endcase
    end

    // ---------------- gain slew ----------------
    // Stepped at capture, so the new gain is already current during MUL_L/MUL_R.
    audio_gain_ramp #(
        .GAIN_W    (GAIN_W),
        .RAMP_STEP (RAMP_STEP)
    ) u_ramp (
        .i_clk_12_288 (i_clk_12_288),
        .i_reset_n    (i_reset_n),
        .i_target     (w_target),
        .i_step_en    (w_capture),
        .o_gain_cur   (w_gain_cur)
    );

    // ---------------- shared multiplier ----------------
    assign w_mul_sample = w_sel_r ? r_sample_r : r_sample_l;
    assign w_mul_a = {{(PROD_W-16){w_mul_sample[15]}}, w_mul_sample};
    // Gain is unsigned: zero-extend so the signed multiply treats it as positive.
    assign w_mul_b = {{(PROD_W-GAIN_W){1'b0}}, w_gain_cur};
    assign w_prod  = w_mul_a * w_mul_b;

    assign w_sat_l = sat16(r_prod_l);
    assign w_sat_r = sat16(r_prod_r);

    // ---------------- datapath ----------------
    always_ff @(posedge i_clk_12_288 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid_d     <= 1'b0;
            r_sample_l    <= '0;
            r_sample_r    <= '0;
            r_prod_l      <= '0;
            r_prod_r      <= '0;
            r_audio_l     <= '0;
            r_audio_r     <= '0;
            r_audio_valid <= 1'b0;
            r_clip        <= 1'b0;
        end else begin
            r_valid_d     <= i_audio_valid;
            r_audio_valid <= w_load_out;
            r_clip        <= w_load_out & (w_sat_l.clip | w_sat_r.clip);
            if (w_capture) begin
                r_sample_l <= i_audio_l;
                r_sample_r <= i_audio_r;
            end
            if (w_load_l) r_prod_l <= w_prod;
            if (w_load_r) r_prod_r <= w_prod;
            if (w_load_out) begin
                r_audio_l <= w_sat_l.sample;
                r_audio_r <= w_sat_r.sample;
            end
        end
    end

    assign o_audio_l     = r_audio_l;
    assign o_audio_r     = r_audio_r;
    assign o_audio_valid = r_audio_valid;
    assign o_clip        = r_clip;
    assign o_gain_cur    = w_gain_cur;

endmodule

// File: tb/tb_audio_gain.sv
`timescale 1ns/1ps
module tb_audio_gain;

    localparam int STEP = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] i_audio_l = '0;
    logic [15:0] i_audio_r = '0;
    logic        i_audio_valid = 1'b0;
    logic [7:0]  i_gain = 8'd128;
    logic        i_mute = 1'b0;
    logic [15:0] o_audio_l;
    logic [15:0] o_audio_r;
    logic        o_audio_valid;
    logic        o_clip;
    logic [7:0]  o_gain_cur;

    int n_chk = 0;
    int n_err = 0;

    always #40 clk = ~clk;

    audio_gain #(.GAIN_W(8), .RAMP_STEP(STEP)) dut (
        .i_clk_12_288  (clk),
        .i_reset_n     (rst_n),
        .i_audio_l     (i_audio_l),
        .i_audio_r     (i_audio_r),
        .i_audio_valid (i_audio_valid),
        .i_gain        (i_gain),
        .i_mute        (i_mute),
        .o_audio_l     (o_audio_l),
        .o_audio_r     (o_audio_r),
        .o_audio_valid (o_audio_valid),
        .o_clip        (o_clip),
        .o_gain_cur    (o_gain_cur)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scale by gain/128 with floor rounding and 16-bit saturation, in plain integers.
    function automatic logic [15:0] scale(input int s, input int g, output bit clip);
        int p;
        int q;
        p = s * g;
        q = p / 128;
        if ((p % 128) != 0 && p < 0) q = q - 1;
        clip = 1'b0;
        if (q > 32767) begin
            q = 32767;
            clip = 1'b1;
        end else if (q < -32768) begin
            q = -32768;
            clip = 1'b1;
        end
        return 16'(q);
    endfunction

    // ---------------- behavioural model ----------------
    // A frame is taken on a strobe rise when no frame is in flight (busy for
    // 3 clocks after acceptance); results show up 3 clocks after acceptance.
    int          m_gain, m_busy, m_due;
    logic        m_prev;
    logic [15:0] m_pl, m_pr;
    logic        m_pc;
    logic [15:0] exp_l, exp_r;
    logic        exp_v, exp_c;

    always @(posedge clk or negedge rst_n) begin : model
        int tgt;
        int g;
        bit cl;
        bit cr;
        logic [15:0] vl;
        logic [15:0] vr;
        if (!rst_n) begin
            m_gain <= 0;
            m_busy <= 0;
            m_due  <= 0;
            m_prev <= 1'b0;
            m_pl   <= '0;
            m_pr   <= '0;
            m_pc   <= 1'b0;
            exp_l  <= '0;
            exp_r  <= '0;
            exp_v  <= 1'b0;
            exp_c  <= 1'b0;
        end else begin
            exp_v <= 1'b0;
            exp_c <= 1'b0;
            if (m_due == 1) begin
                exp_l <= m_pl;
                exp_r <= m_pr;
                exp_v <= 1'b1;
                exp_c <= m_pc;
            end
            if (m_due > 0) m_due <= m_due - 1;
            if (i_audio_valid && !m_prev && m_busy == 0) begin
                tgt = i_mute ? 0 : int'(i_gain);
                g = m_gain;
                if (g < tgt) g = (tgt - g > STEP) ? g + STEP : tgt;
                else if (g > tgt) g = (g - tgt > STEP) ? g - STEP : tgt;
                vl = scale(int'($signed(i_audio_l)), g, cl);
                vr = scale(int'($signed(i_audio_r)), g, cr);
                m_gain <= g;
                m_pl   <= vl;
                m_pr   <= vr;
                m_pc   <= cl | cr;
                m_due  <= 3;
                m_busy <= 3;
            end else if (m_busy > 0) begin
                m_busy <= m_busy - 1;
            end
            m_prev <= i_audio_valid;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("o_audio_l", 32'(o_audio_l), 32'(exp_l));
        check("o_audio_r", 32'(o_audio_r), 32'(exp_r));
        check("o_audio_valid", 32'(o_audio_valid), 32'(exp_v));
        check("o_clip", 32'(o_clip), 32'(exp_c));
        check("o_gain_cur", 32'(o_gain_cur), 32'(m_gain));
    end

    // ---------------- directed stimulus ----------------
    logic [15:0] f_l, f_r;
    logic        f_c;
    logic [7:0]  f_g;

    // One strobe pulse; returns the outputs seen with the resulting o_audio_valid.
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                              output logic [15:0] ol, output logic [15:0] orr,
                              output logic oc, output logic [7:0] og);
        bit got;
        @(negedge clk);
        i_audio_l = l;
        i_audio_r = r;
        i_audio_valid = 1'b1;
        @(negedge clk);
        i_audio_valid = 1'b0;
        got = 1'b0;
        ol = '0; orr = '0; oc = 1'b0; og = '0;
        for (int k = 0; k < 10 && !got; k++) begin
            if (o_audio_valid) begin
                got = 1'b1;
                ol = o_audio_l;
                orr = o_audio_r;
                oc = o_clip;
                og = o_gain_cur;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) check("frame_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #4_800_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int pulses;
        int lat;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_l", 32'(o_audio_l), 32'h0);
        check("rst_valid", 32'(o_audio_valid), 32'h0);
        check("rst_gain", 32'(o_gain_cur), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fade-in from 0 to unity
        i_gain = 8'd128;
        for (int n = 1; n <= 130; n++) begin
            send_frame(16'h4000, 16'hC000, f_l, f_r, f_c, f_g);
            check("fade_gain", 32'(f_g), 32'((n < 128) ? n : 128));
            if (n == 1) begin
                check("fade1_l", 32'(f_l), 32'h0080);
                check("fade1_r", 32'(f_r), 32'hFF80);
            end
            if (n == 128 || n == 130) begin
                check("fade128_l", 32'(f_l), 32'h4000);
                check("fade128_r", 32'(f_r), 32'hC000);
                check("fade128_clip", 32'(f_c), 32'h0);
            end
        end

        // Soft mute down, then release back to unity
        i_mute = 1'b1;
        for (int n = 1; n <= 129; n++) begin
            send_frame(16'h4000, 16'hC000, f_l, f_r, f_c, f_g);
            check("mute_gain", 32'(f_g), 32'((n < 128) ? 128 - n : 0));
            if (n == 1) check("mute1_l", 32'(f_l), 32'h3F80);
            if (n >= 128) begin
                check("mute_l0", 32'(f_l), 32'h0);
                check("mute_r0", 32'(f_r), 32'h0);
            end
        end
        i_mute = 1'b0;
        for (int n = 1; n <= 128; n++) begin
            send_frame(16'h4000, 16'hC000, f_l, f_r, f_c, f_g);
            check("unmute_gain", 32'(f_g), 32'(n));
        end
        check("unmute_l", 32'(f_l), 32'h4000);

        // Strobe held two cycles: one output, 4 cycles after the rise
        @(negedge clk);
        i_audio_valid = 1'b1;
        pulses = 0;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 2) i_audio_valid = 1'b0;
            if (o_audio_valid) begin
                pulses++;
                if (lat == 0) lat = k;
            end
        end
        check("strobe2_pulses", 32'(pulses), 32'd1);
        check("strobe2_latency", 32'(lat), 32'd4);

        // Second rise while busy is ignored
        @(negedge clk);
        i_audio_valid = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) i_audio_valid = 1'b0;
            if (k == 2) i_audio_valid = 1'b1;
            if (k == 3) i_audio_valid = 1'b0;
            if (o_audio_valid) pulses++;
        end
        check("busy_rise_pulses", 32'(pulses), 32'd1);

        // Saturation at maximum gain
        i_gain = 8'd255;
        for (int n = 1; n <= 127; n++) send_frame(16'h1000, 16'h0000, f_l, f_r, f_c, f_g);
        check("sat_gain", 32'(f_g), 32'd255);
        send_frame(16'h7FFF, 16'h8000, f_l, f_r, f_c, f_g);
        check("sat_l", 32'(f_l), 32'h7FFF);
        check("sat_r", 32'(f_r), 32'h8000);
        check("sat_clip", 32'(f_c), 32'h1);
        send_frame(16'h2000, 16'h0000, f_l, f_r, f_c, f_g);
        check("nosat_l", 32'(f_l), 32'h3FC0);
        check("nosat_clip", 32'(f_c), 32'h0);

        // Floor rounding at half gain
        i_gain = 8'd64;
        for (int n = 1; n <= 191; n++) send_frame(16'h0100, 16'h0000, f_l, f_r, f_c, f_g);
        check("half_gain", 32'(f_g), 32'd64);
        send_frame(16'hFFFF, 16'h0000, f_l, f_r, f_c, f_g);
        check("floor_neg", 32'(f_l), 32'hFFFF);
        send_frame(16'h0001, 16'h4000, f_l, f_r, f_c, f_g);
        check("floor_pos", 32'(f_l), 32'h0000);
        check("floor_r", 32'(f_r), 32'h2000);

        // Reset while the frame is in MUL_R
        @(negedge clk);
        i_audio_l = 16'h4000;
        i_audio_r = 16'h4000;
        i_audio_valid = 1'b1;
        @(negedge clk);
        i_audio_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_l", 32'(o_audio_l), 32'h0);
        check("midrst_r", 32'(o_audio_r), 32'h0);
        check("midrst_gain", 32'(o_gain_cur), 32'h0);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (o_audio_valid) pulses++;
        end
        check("midrst_pulses", 32'(pulses), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(16'h4000, 16'hC000, f_l, f_r, f_c, f_g);
        check("postrst_gain", 32'(f_g), 32'd1);
        check("postrst_l", 32'(f_l), 32'h0080);
        check("postrst_r", 32'(f_r), 32'hFF80);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
